// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of pipeline write-back, long-latency result, register
//               file write and hazard-check signals around the write-port
//               arbiter. "slave" is the arbiter side, "master" its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int DW = 64,
    parameter int AW = 5
);
    // Pipeline write-back
    logic          wb_wreg;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    // Long-latency unit result handshake
    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_rd;
    logic [DW-1:0] lu_data;
    // Register-file write port
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    // Pipeline hold request
    logic          stall_req;
    // Hazard check for the instruction in decode
    logic [AW-1:0] chk_rd1;
    logic [AW-1:0] chk_rd2;
    logic          pend_hit1;
    logic          pend_hit2;

    modport slave (
        input  wb_wreg, wb_rd, wb_data,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        output rf_we, rf_waddr, rf_wdata,
        output stall_req,
        input  chk_rd1, chk_rd2,
        output pend_hit1, pend_hit2
    );

    modport master (
        output wb_wreg, wb_rd, wb_data,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  stall_req,
        output chk_rd1, chk_rd2,
        input  pend_hit1, pend_hit2
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between in-order
//               pipeline write-backs and queued long-latency results. A queue
//               head left unserved for STARVE_LIMIT cycles forces a one-cycle
//               pipeline stall so it can drain. Pending queued destinations
//               are exported for the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int DW           = 64,
    parameter int AW           = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_port_arbiter_if.slave bus
);
    // Pointer width; count needs one extra bit to represent a full queue
    localparam int c_pw   = $clog2(DEPTH);
    localparam int c_cw   = c_pw + 1;
    localparam int c_agew = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_cw-1:0]   c_depth = c_cw'(DEPTH);
    localparam logic [c_agew-1:0] c_limit = c_agew'(STARVE_LIMIT);
    localparam logic [AW-1:0]     c_xzr   = AW'(31);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_force = 2'd2;

    logic [AW-1:0]     r_mem_rd   [DEPTH];
    logic [DW-1:0]     r_mem_data [DEPTH];
    logic [c_pw-1:0]   r_rptr;
    logic [c_pw-1:0]   r_wptr;
    logic [c_cw-1:0]   r_count;
    logic [c_cw-1:0]   w_count_n;
    logic [c_agew-1:0] r_age;
    logic [c_agew-1:0] w_age_n;
    logic [1:0]        r_state;
    logic [1:0]        w_state_n;
    logic              r_stall;

    logic              w_ready;
    logic              w_hs;
    logic              w_push;
    logic              w_head_valid;
    logic              w_grant_q;
    logic              w_grant_p;
    logic              w_pop;
    logic [AW-1:0]     w_head_rd;
    logic [DW-1:0]     w_head_data;
    logic [DEPTH-1:0]  w_hit1_vec;
    logic [DEPTH-1:0]  w_hit2_vec;

    // Acceptance depends on the registered count only: a pop in the same
    // cycle does not open a slot, which keeps lu_ready free of grant logic.
    assign w_ready      = (r_count < c_depth);
    assign w_hs         = bus.lu_valid && w_ready;
    assign w_push       = w_hs && (bus.lu_rd != c_xzr);
    assign w_head_valid = (r_count != '0);
    assign w_head_rd    = r_mem_rd[r_rptr];
    assign w_head_data  = r_mem_data[r_rptr];

    // Port selection: forced head, then pipeline, then head on a free port
    always_comb begin
        w_grant_q = 1'b0;
        w_grant_p = 1'b0;
        if (r_stall && w_head_valid) begin
            w_grant_q = 1'b1;
        end else if (bus.wb_wreg && (bus.wb_rd != c_xzr)) begin
            w_grant_p = 1'b1;
        end else if (w_head_valid) begin
            w_grant_q = 1'b1;
        end
    end

    assign w_pop         = w_grant_q;
    assign bus.rf_we     = rst_n && (w_grant_q || w_grant_p);
    assign bus.rf_waddr  = w_grant_q ? w_head_rd   : bus.wb_rd;
    assign bus.rf_wdata  = w_grant_q ? w_head_data : bus.wb_data;
    assign bus.lu_ready  = w_ready;
    assign bus.stall_req = r_stall;

    assign w_count_n = r_count + c_cw'(w_push) - c_cw'(w_pop);

    // Queue payload storage; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= bus.lu_rd;
            r_mem_data[r_wptr] <= bus.lu_data;
        end
    end

    // Queue occupancy and wrapping pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_rptr  <= '0;
            r_wptr  <= '0;
        end else begin
            r_count <= w_count_n;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Head age: counts ungranted cycles of a valid head, saturating
    always_comb begin
        w_age_n = r_age;
        if (!w_head_valid || w_pop) begin
            w_age_n = '0;
        end else if (r_age != c_limit) begin
            w_age_n = r_age + 1'b1;
        end
    end

    // Starvation FSM next state
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_push) begin
                    w_state_n = c_st_wait;
                end
            end
            c_st_wait: begin
                if (w_count_n == '0) begin
                    w_state_n = c_st_idle;
                end else if (w_head_valid && !w_pop && (w_age_n == c_limit)) begin
                    w_state_n = c_st_force;
                end
            end
            c_st_force: begin
                w_state_n = (w_count_n != '0) ? c_st_wait : c_st_idle;
            end
            default: begin
                w_state_n = c_st_idle;
            end
        endcase
    end

    // State, age and the registered stall request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_age   <= '0;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_age   <= w_age_n;
            r_stall <= (w_state_n == c_st_force);
        end
    end

    // Per-entry destination match against both decode source registers
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [c_pw-1:0] w_off;
        logic            w_valid;
        assign w_off          = c_pw'(gi) - r_rptr;
        assign w_valid        = ({1'b0, w_off} < r_count);
        assign w_hit1_vec[gi] = w_valid && (r_mem_rd[gi] == bus.chk_rd1);
        assign w_hit2_vec[gi] = w_valid && (r_mem_rd[gi] == bus.chk_rd2);
    end

    // A result being accepted this cycle is already pending for the hazard unit
    assign bus.pend_hit1 = (bus.chk_rd1 != c_xzr) &&
                           ((|w_hit1_vec) || (w_hs && (bus.lu_rd == bus.chk_rd1)));
    assign bus.pend_hit2 = (bus.chk_rd2 != c_xzr) &&
                           ((|w_hit2_vec) || (w_hs && (bus.lu_rd == bus.chk_rd2)));

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter and scheduler for the single register-file write port driven by the write-back stage. It shares the port between in-order pipeline write-backs and out-of-order results from a long-latency unit (multiply/divide), buffering the latter in a small queue. It forces a one-cycle write-back stall when a queued result has waited too long. It also exports pending-destination flags so the hazard unit can hold dependent instructions.

## Interface
Parameters:
- DEPTH, 2: long-latency result queue entries (power of two, ≥2)
- STARVE_LIMIT, 4: cycles a queue head may go unserved before a forced grant (≥1)
- DW, 64: data width
- AW, 5: register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_wreg  in  1  pipeline write-back enable (WB-stage wregout)
- wb_rd  in  AW  pipeline destination register
- wb_data  in  DW  pipeline write data (WB mux output)
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  queue can accept a result
- lu_rd  in  AW  long-latency destination register
- lu_data  in  DW  long-latency result
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- stall_req  out  1  registered; pipeline must hold its WB instruction this cycle
- chk_rd1, chk_rd2  in  AW  source registers of the instruction in decode
- pend_hit1, pend_hit2  out  1  source matches a pending long-latency destination

## Operation
- Queue: DEPTH-entry FIFO of {rd, data}, with registered count, read pointer and write pointer; pointers wrap modulo DEPTH.
- Enqueue when lu_valid && lu_ready. lu_rd = 31 (XZR) completes the handshake but is discarded and not enqueued.
- lu_ready = (count < DEPTH), derived from registered count only. A same-cycle pop does not free a slot.
- Port selection, in priority order, evaluated combinationally each cycle:
  - stall_req = 1 and queue non-empty: grant queue head. The pipeline write is suppressed; the pipeline re-presents it next cycle.
  - wb_wreg = 1 and wb_rd ≠ 31: grant pipeline.
  - queue non-empty: grant queue head.
  - otherwise rf_we = 0.
- A pipeline write to XZR leaves the port free for the queue head in that cycle.
- Pop the queue head on its grant. rf_we, rf_waddr and rf_wdata reflect the granted source. When nothing is granted, rf_waddr and rf_wdata are don't-care.
- Age counter: increments while the head is valid and not granted; clears on pop or when the queue is empty. Width is ceil(log2(STARVE_LIMIT+1)) and it saturates.
- FSM states:
  - IDLE: queue empty. Go to WAIT on an enqueue.
  - WAIT: head pending. Go to FORCE at the edge where age reaches STARVE_LIMIT. Go to IDLE when the queue empties.
  - FORCE: stall_req = 1 for exactly one cycle; the head is granted. Next state is WAIT (age = 0) if entries remain, else IDLE.
- pend_hitN = 1 if chk_rdN ≠ 31 and chk_rdN equals the rd of any valid queue entry or of an accepted lu handshake in the current cycle.
- Ordering rule: WAW and RAW between queued and pipeline writes are prevented by the hazard unit acting on pend_hit. The arbiter does not reorder or merge writes.

## Timing
- Reset (rst_n low, asynchronous):
  - count, pointers and age = 0; state = IDLE; stall_req = 0.
  - rf_we forced 0 while rst_n is low; lu_ready = 1 after reset.
  - Queue contents are lost. The long-latency unit shares rst_n.
- Pipeline write latency is 0: wb_* propagate to rf_* in the same cycle.
- Long-latency write: earliest at the cycle after acceptance (no bypass). Worst case from head is STARVE_LIMIT + 1 cycles.
- Both sources active and no stall: the pipeline wins, the head ages.
- Full queue: lu_ready = 0; the producer holds lu_* stable until accepted.
- Enqueue and pop in the same cycle: count is unchanged, both pointers advance.
- stall_req changes only on clock edges and is never asserted with an empty queue.

## Test plan
- Reset: assert rst_n = 0 mid-FORCE with 2 entries queued → stall_req = 0, rf_we = 0, lu_ready = 1 immediately; after release, no stale write occurs.
- Idle port: lu result {rd = 5, data = 0xDEAD} with wb_wreg = 0 → accepted at cycle t; rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEAD at t+1; pend_hit1 = 1 for chk_rd1 = 5 from t until the write.
- Starvation (STARVE_LIMIT = 4): queue rd = 7, wb_wreg held at 1 with rd = 3 → pipeline writes 4 cycles, stall_req = 1 in cycle 5, rd = 7 is written then, and the rd = 3 write resumes in cycle 6.
- Full queue: three back-to-back lu results with the port busy → third sees lu_ready = 0 until the first drains; FIFO order is preserved.
- XZR: lu_rd = 31 → handshake completes, count stays 0, no write. wb_rd = 31 with a queued entry → the queued entry is written in that cycle.
- Wrap: 10 alternating enqueue/pop pairs → pointers wrap; data and addresses appear in issue order with no loss or duplication.
